// File: rtl/matrix_stream_loader_if.sv
// Stream-in / matrix-out bundle between the element feeder, the loader and the inverse stage.
// The slave side is the loader; the master side drives elements and consumes matrices.
interface matrix_stream_loader_if #(
  parameter int N = 5,
  parameter int W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             mat_valid;
  logic             mat_ready;
  logic [N*N*W-1:0] mat_flat;
  logic             frame_err;
  logic [7:0]       frame_cnt;

  modport slave (
    input  in_valid, in_data, in_last, mat_ready,
    output in_ready, mat_valid, mat_flat, frame_err, frame_cnt
  );

  modport master (
    output in_valid, in_data, in_last, mat_ready,
    input  in_ready, mat_valid, mat_flat, frame_err, frame_cnt
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Collects N*N row-major elements into a shadow buffer and publishes each complete
// frame atomically on mat_flat; malformed frames are dropped with a frame_err pulse.
module matrix_stream_loader #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  matrix_stream_loader_if.slave  m
);
  localparam int NE    = N * N;
  localparam int IDX_W = $clog2(NE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NE - 1);

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mat_valid_q, mat_valid_d;
  logic [NE*W-1:0]   mat_flat_q, mat_flat_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [W-1:0]      shadow_q [NE];
  logic              accept;

  assign m.in_ready  = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign accept      = m.in_valid && m.in_ready;
  assign m.mat_valid = mat_valid_q;
  assign m.mat_flat  = mat_flat_q;
  assign m.frame_err = frame_err_q;
  assign m.frame_cnt = frame_cnt_q;

  // Shadow buffer carries no reset: every slot is rewritten before it can be published.
  always_ff @(posedge clk) begin
    if (accept && state_q == S_LOAD) begin
      shadow_q[idx_q] <= m.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      mat_valid_q <= 1'b0;
      mat_flat_q  <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mat_valid_q <= mat_valid_d;
      mat_flat_q  <= mat_flat_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mat_valid_d = mat_valid_q;
    mat_flat_d  = mat_flat_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (m.in_last) begin
              // The final element bypasses the shadow so the whole frame lands in one edge.
              for (int k = 0; k < NE - 1; k++) begin
                mat_flat_d[k*W +: W] = shadow_q[k];
              end
              mat_flat_d[(NE-1)*W +: W] = m.in_data;
              mat_valid_d = 1'b1;
              state_d     = S_HOLD;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_DRAIN;
            end
          end else if (m.in_last) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (accept && m.in_last) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_HOLD: begin
        if (mat_valid_q && m.mat_ready) begin
          mat_valid_d = 1'b0;
          state_d     = S_LOAD;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: frame table plus hand-written corner sequences,
// with a queue of expected matrices popped at each hand-off.
module tb_matrix_stream_loader;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NE = N * N;

  typedef logic [NE*W-1:0] flat_t;

  typedef struct {
    int         len;
    int         last_at;
    int         mode;
    logic [7:0] base;
    bit         exp_err;
    bit         exp_del;
  } frame_vec_t;

  logic clk = 1'b0;
  logic reset;
  matrix_stream_loader_if #(.N(N), .W(W)) bus ();

  matrix_stream_loader #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  int         handoffs = 0;
  logic [7:0] exp_frames = 8'd0;
  flat_t      sb [$];
  flat_t      prev_flat;
  logic       pend_q = 1'b0;
  bit         throttle = 1'b0;

  task automatic chk(input string name, input flat_t act, input flat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Hand-off monitor and hold-stability checker, sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_pulses++;
    if (pend_q && !reset) chk("flat_stable", bus.mat_flat, prev_flat);
    if (!reset && bus.mat_valid && bus.mat_ready) begin
      handoffs++;
      if (sb.size() == 0) begin
        chk("unexpected_handoff", 1, 0);
      end else begin
        chk("handoff_flat", bus.mat_flat, sb.pop_front());
      end
    end
    pend_q    <= bus.mat_valid && !bus.mat_ready && !reset;
    prev_flat <= bus.mat_flat;
  end

  function automatic logic [7:0] elem(input int mode, input logic [7:0] base, input int k);
    case (mode)
      1:       return base;
      2:       return (k % (N + 1) == 0) ? 8'd1 : 8'd0;
      default: return base + 8'(k);
    endcase
  endfunction

  // Called and returning at a falling edge; the beat is accepted on the rising edge in between.
  task automatic beat(input logic [7:0] d, input logic l);
    int n = 0;
    if (throttle) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input int last_at, input int mode,
                            input logic [7:0] base, input bit deliver);
    flat_t e = '0;
    for (int k = 0; k < len && k < NE; k++) e[k*W +: W] = elem(mode, base, k);
    if (deliver) begin
      sb.push_back(e);
      exp_frames = exp_frames + 8'd1;
    end
    for (int k = 0; k < len; k++) beat(elem(mode, base, k), (k + 1) == last_at);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_frames = 8'd0;
    sb.delete();
    @(negedge clk);
  endtask

  frame_vec_t vecs [7];

  initial begin
    int e0;
    int h0;
    vecs[0] = '{25, 25, 0, 8'h10, 1'b0, 1'b1};
    vecs[1] = '{10, 10, 0, 8'h40, 1'b1, 1'b0};
    vecs[2] = '{25, 25, 1, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{28, 28, 0, 8'h80, 1'b1, 1'b0};
    vecs[4] = '{25, 25, 0, 8'hC0, 1'b0, 1'b1};
    vecs[5] = '{1,  1,  1, 8'h33, 1'b1, 1'b0};
    vecs[6] = '{25, 25, 2, 8'h00, 1'b0, 1'b1};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.mat_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mat_valid", bus.mat_valid, 0);
    chk("rst_mat_flat",  bus.mat_flat, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_in_ready",  bus.in_ready, 1);

    // Values 1..25, hand-off latency
    send_frame(25, 25, 0, 8'd1, 1'b1);
    chk("t1_latency_valid", bus.mat_valid, 1);
    chk("t1_elem0",  bus.mat_flat[7:0], 8'd1);
    chk("t1_elem24", bus.mat_flat[199:192], 8'd25);
    @(negedge clk);
    chk("t1_frame_cnt", bus.frame_cnt, 1);

    // Identity held under back-pressure
    bus.mat_ready = 1'b0;
    h0 = handoffs;
    send_frame(25, 25, 2, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", bus.mat_valid, 1);
      chk("t2_hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.mat_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t2_one_handoff", handoffs - h0, 1);
    chk("t2_valid_low", bus.mat_valid, 0);
    chk("t2_frame_cnt", bus.frame_cnt, exp_frames);

    // Frame table: clean, short, long, single-beat short and identity frames
    for (int v = 0; v < 7; v++) begin
      e0 = err_pulses;
      send_frame(vecs[v].len, vecs[v].last_at, vecs[v].mode, vecs[v].base, vecs[v].exp_del);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_err", v), err_pulses - e0, vecs[v].exp_err ? 1 : 0);
      chk($sformatf("vec%0d_cnt", v), bus.frame_cnt, exp_frames);
      chk($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
    end

    // Random in_valid gaps over three frames
    throttle = 1'b1;
    h0 = handoffs;
    for (int f = 0; f < 3; f++) send_frame(25, 25, 0, 8'(8'h20 + 8'(f * 40)), 1'b1);
    throttle = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_handoffs", handoffs - h0, 3);
    chk("t5_frame_cnt", bus.frame_cnt, exp_frames);

    // Reset in the middle of a frame
    send_frame(12, 0, 1, 8'hEE, 1'b0);
    do_reset();
    chk("t6_mat_valid", bus.mat_valid, 0);
    chk("t6_mat_flat",  bus.mat_flat, 0);
    chk("t6_frame_err", bus.frame_err, 0);
    chk("t6_frame_cnt", bus.frame_cnt, 0);
    chk("t6_in_ready",  bus.in_ready, 1);
    send_frame(25, 25, 0, 8'h60, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_frame_cnt_after", bus.frame_cnt, 1);
    chk("t6_sb_empty", sb.size(), 0);

    // frame_cnt wrap
    do_reset();
    for (int f = 0; f < 255; f++) send_frame(25, 25, 0, 8'(f), 1'b1);
    repeat (2) @(negedge clk);
    chk("t7_cnt_255", bus.frame_cnt, 8'd255);
    send_frame(25, 25, 1, 8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    chk("t7_cnt_wrap", bus.frame_cnt, 8'd0);
    chk("t7_sb_empty", sb.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
